// File: rtl/calculator_n.sv
// calculator_n: two-operand calculator with debounced buttons/sliders,
// a small enter/compute FSM and a multiplexed active-low 7-segment display.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ENTER_A | sliders shown live; ent loads A
// ENTER_B | sliders shown live; ent loads B and computes A op B
// RESULT  | result shown; ent chains result into A and returns to ENTER_B
module calculator_n #(
  parameter int WIDTH            = 4,
  parameter int NUM_DIGITS       = 4,
  parameter int DB_OVERFLOW      = 1000000,
  parameter int REFRESH_OVERFLOW = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  button_ent_undeb,
  input  logic                  button_clr_undeb,
  input  logic [WIDTH-1:0]      slider_undeb,
  input  logic [1:0]            op_select_undeb,
  output logic [NUM_DIGITS-1:0] digit_select,
  output logic [6:0]            led_select,
  output logic                  ovf,
  output logic [1:0]            state
);

  // Raw inputs packed as {op, sliders, clr, ent}
  localparam int NB       = WIDTH + 4;
  localparam int DB_CNT_W = (DB_OVERFLOW > 1) ? $clog2(DB_OVERFLOW) : 1;
  localparam int REF_W    = (REFRESH_OVERFLOW > 1) ? $clog2(REFRESH_OVERFLOW) : 1;
  localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DISP_W   = 4 * NUM_DIGITS;

  localparam logic [DB_CNT_W-1:0] DB_LAST  = DB_CNT_W'(DB_OVERFLOW - 1);
  localparam logic [REF_W-1:0]    REF_LAST = REF_W'(REFRESH_OVERFLOW - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    ENTER_A = 2'b00,
    ENTER_B = 2'b01,
    RESULT  = 2'b10
  } state_t;

  logic [NB-1:0] raw;
  logic [NB-1:0] sync1_q;
  logic [NB-1:0] sync2_q;
  logic [NB-1:0] deb;
  logic [1:0]    btn_dly_q;

  logic             ent_pulse;
  logic             clr_pulse;
  logic [WIDTH-1:0] sliders_deb;
  logic [1:0]       op_deb;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;

  logic [REF_W-1:0]  ref_cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic [WIDTH-1:0]  disp_val;
  logic [DISP_W-1:0] disp_ext;
  logic [3:0]        nib;

  assign raw = {op_select_undeb, slider_undeb, button_clr_undeb, button_ent_undeb};

  // Two-flop synchroniser on every raw input bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit debouncer: accept a new level only after it has persisted
  // for DB_OVERFLOW consecutive cycles; any return to the old level restarts.
  for (genvar gi = 0; gi < NB; gi++) begin : g_db
    logic [DB_CNT_W-1:0] cnt_q;
    logic                bit_q;

    // Stability counter and accepted level for one input bit
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
        bit_q <= 1'b0;
      end else if (sync2_q[gi] == bit_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DB_LAST) begin
        cnt_q <= '0;
        bit_q <= sync2_q[gi];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign deb[gi] = bit_q;
  end

  assign sliders_deb = deb[WIDTH+1:2];
  assign op_deb      = deb[WIDTH+3:WIDTH+2];

  // Delayed button levels for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_dly_q <= '0;
    end else begin
      btn_dly_q <= deb[1:0];
    end
  end

  assign ent_pulse = deb[0] & ~btn_dly_q[0];
  assign clr_pulse = deb[1] & ~btn_dly_q[1];

  // ALU on current A and live debounced sliders (becomes B on compute)
  always_comb begin
    sum_w   = {1'b0, a_q} + {1'b0, sliders_deb};
    diff_w  = {1'b0, a_q} - {1'b0, sliders_deb};
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op_deb)
      2'b00: begin
        alu_res = sum_w[WIDTH-1:0];
        alu_ovf = sum_w[WIDTH];
      end
      2'b01: begin
        alu_res = diff_w[WIDTH-1:0];
        alu_ovf = diff_w[WIDTH];
      end
      2'b10: alu_res = a_q & sliders_deb;
      default: alu_res = a_q ^ sliders_deb;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ENTER_A;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; clear always wins over enter
  always_comb begin
    state_d = state_q;
    if (clr_pulse) begin
      state_d = ENTER_A;
    end else if (ent_pulse) begin
      case (state_q)
        ENTER_A: state_d = ENTER_B;
        ENTER_B: state_d = RESULT;
        RESULT:  state_d = ENTER_B;
        default: state_d = ENTER_A;
      endcase
    end else if (state_q != ENTER_A && state_q != ENTER_B && state_q != RESULT) begin
      state_d = ENTER_A;
    end
  end

  // FSM outputs: operand/result register updates per state
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    if (clr_pulse) begin
      a_d      = '0;
      b_d      = '0;
      result_d = '0;
      ovf_d    = 1'b0;
    end else if (ent_pulse) begin
      case (state_q)
        ENTER_A: a_d = sliders_deb;
        ENTER_B: begin
          b_d      = sliders_deb;
          result_d = alu_res;
          ovf_d    = alu_ovf;
        end
        RESULT:  a_d = result_q;
        default: ;
      endcase
    end
  end

  // Operand, result and flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ovf   = ovf_q;
  assign state = state_q;

  // Digit refresh: hold each digit REFRESH_OVERFLOW cycles, then rotate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt_q <= '0;
      idx_q     <= '0;
    end else if (ref_cnt_q == REF_LAST) begin
      ref_cnt_q <= '0;
      idx_q     <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      ref_cnt_q <= ref_cnt_q + 1'b1;
    end
  end

  // Select the nibble for the active digit from the zero-extended value
  always_comb begin
    disp_val = (state_q == RESULT) ? result_q : sliders_deb;
    disp_ext = '0;
    disp_ext[WIDTH-1:0] = disp_val;
    nib          = '0;
    digit_select = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        nib             = disp_ext[k*4 +: 4];
        digit_select[k] = 1'b0;
      end
    end
  end

  // Hex to active-low segments {g,f,e,d,c,b,a}
  always_comb begin
    case (nib)
      4'h0: led_select = 7'b1000000;
      4'h1: led_select = 7'b1111001;
      4'h2: led_select = 7'b0100100;
      4'h3: led_select = 7'b0110000;
      4'h4: led_select = 7'b0011001;
      4'h5: led_select = 7'b0010010;
      4'h6: led_select = 7'b0000010;
      4'h7: led_select = 7'b1111000;
      4'h8: led_select = 7'b0000000;
      4'h9: led_select = 7'b0010000;
      4'hA: led_select = 7'b0001000;
      4'hB: led_select = 7'b0000011;
      4'hC: led_select = 7'b1000110;
      4'hD: led_select = 7'b0100001;
      4'hE: led_select = 7'b0000110;
      default: led_select = 7'b0001110;
    endcase
  end

endmodule

// File: tb/tb_calculator_n.sv
// Directed bench for calculator_n with short debounce/refresh periods.
module tb_calculator_n;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ent = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] sliders = '0;
  logic [1:0] op = '0;
  logic [3:0] digit_select;
  logic [6:0] led_select;
  logic       ovf;
  logic [1:0] state;

  int n_pass = 0;
  int n_total = 0;

  calculator_n #(
    .WIDTH(4), .NUM_DIGITS(4), .DB_OVERFLOW(8), .REFRESH_OVERFLOW(2)
  ) dut (
    .clk(clk), .rst(rst),
    .button_ent_undeb(ent), .button_clr_undeb(clr),
    .slider_undeb(sliders), .op_select_undeb(op),
    .digit_select(digit_select), .led_select(led_select),
    .ovf(ovf), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [3:0] res;
    logic       ovf;
  } vec_t;

  vec_t vt[8];

  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000; 4'h1: return 7'b1111001;
      4'h2: return 7'b0100100; 4'h3: return 7'b0110000;
      4'h4: return 7'b0011001; 4'h5: return 7'b0010010;
      4'h6: return 7'b0000010; 4'h7: return 7'b1111000;
      4'h8: return 7'b0000000; 4'h9: return 7'b0010000;
      4'hA: return 7'b0001000; 4'hB: return 7'b0000011;
      4'hC: return 7'b1000110; 4'hD: return 7'b0100001;
      4'hE: return 7'b0000110; default: return 7'b0001110;
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_ent();
    @(negedge clk); ent = 1'b1;
    cycles(14);
    ent = 1'b0;
    cycles(14);
  endtask

  task automatic press_clr();
    @(negedge clk); clr = 1'b1;
    cycles(14);
    clr = 1'b0;
    cycles(14);
  endtask

  // Wait (bounded) for digit k to be selected, then check its segments
  task automatic check_digit(input string nm, input int k, input logic [6:0] exp);
    logic [3:0] want;
    int n;
    want = 4'b1111;
    want[k] = 1'b0;
    n = 0;
    @(negedge clk);
    while (digit_select != want && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk({nm, "_sel_timeout"}, int'(digit_select), int'(want));
    else chk(nm, int'(led_select), int'(exp));
  endtask

  initial begin
    vt[0] = '{a: 4'h9, b: 4'h8, op: 2'b00, res: 4'h1, ovf: 1'b1};
    vt[1] = '{a: 4'h3, b: 4'h5, op: 2'b01, res: 4'hE, ovf: 1'b1};
    vt[2] = '{a: 4'h2, b: 4'h3, op: 2'b00, res: 4'h5, ovf: 1'b0};
    vt[3] = '{a: 4'h7, b: 4'h2, op: 2'b01, res: 4'h5, ovf: 1'b0};
    vt[4] = '{a: 4'hC, b: 4'hA, op: 2'b10, res: 4'h8, ovf: 1'b0};
    vt[5] = '{a: 4'hC, b: 4'hA, op: 2'b11, res: 4'h6, ovf: 1'b0};
    vt[6] = '{a: 4'hF, b: 4'h1, op: 2'b00, res: 4'h0, ovf: 1'b1};
    vt[7] = '{a: 4'h5, b: 4'h5, op: 2'b01, res: 4'h0, ovf: 1'b0};

    // Reset values and digit rotation
    cycles(3);
    chk("rst_state", int'(state), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_digit_sel", int'(digit_select), 4'b1110);
    chk("rst_led", int'(led_select), 7'b1000000);
    rst = 1'b0;
    begin
      logic [3:0] rot [4];
      rot[0] = 4'b1101; rot[1] = 4'b1011; rot[2] = 4'b0111; rot[3] = 4'b1110;
      for (int i = 0; i < 4; i++) begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk($sformatf("rotate_%0d", i), int'(digit_select), int'(rot[i]));
      end
    end

    // Table-driven compute vectors
    for (int i = 0; i < 8; i++) begin
      press_clr();
      chk($sformatf("v%0d_clr_state", i), int'(state), 0);
      sliders = vt[i].a;
      cycles(14);
      press_ent();
      chk($sformatf("v%0d_stateB", i), int'(state), 1);
      chk($sformatf("v%0d_A", i), int'(dut.a_q), int'(vt[i].a));
      sliders = vt[i].b;
      op = vt[i].op;
      cycles(14);
      press_ent();
      chk($sformatf("v%0d_stateR", i), int'(state), 2);
      chk($sformatf("v%0d_result", i), int'(dut.result_q), int'(vt[i].res));
      chk($sformatf("v%0d_ovf", i), int'(ovf), int'(vt[i].ovf));
      check_digit($sformatf("v%0d_dig0", i), 0, seg(vt[i].res));
      check_digit($sformatf("v%0d_dig1", i), 1, 7'b1000000);
      check_digit($sformatf("v%0d_dig3", i), 3, 7'b1000000);
    end

    // Subtract with borrow, then chain the result into A
    press_clr();
    sliders = 4'h3; op = 2'b01;
    cycles(14);
    press_ent();
    sliders = 4'h5;
    cycles(14);
    press_ent();
    chk("chain_pre_state", int'(state), 2);
    check_digit("chain_dig0", 0, 7'b0000110);
    press_ent();
    chk("chain_state", int'(state), 1);
    chk("chain_A", int'(dut.a_q), 4'hE);
    chk("chain_ovf_hold", int'(ovf), 1);

    // Clear and enter together in ENTER_B: clear wins
    @(negedge clk); ent = 1'b1; clr = 1'b1;
    cycles(14);
    ent = 1'b0; clr = 1'b0;
    cycles(14);
    chk("clrprio_state", int'(state), 0);
    chk("clrprio_ovf", int'(ovf), 0);
    chk("clrprio_A", int'(dut.a_q), 0);
    chk("clrprio_B", int'(dut.b_q), 0);
    chk("clrprio_result", int'(dut.result_q), 0);

    // Bounce rejection, then one clean press
    @(negedge clk); ent = 1'b1;
    cycles(5);
    ent = 1'b0;
    cycles(20);
    chk("bounce_state", int'(state), 0);
    press_ent();
    chk("clean_state", int'(state), 1);
    cycles(30);
    chk("clean_state_hold", int'(state), 1);

    // Async reset mid-debounce
    sliders = 4'hF;
    cycles(14);
    @(negedge clk); ent = 1'b1;
    cycles(5);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_state", int'(state), 0);
    chk("arst_ovf", int'(ovf), 0);
    chk("arst_digit_sel", int'(digit_select), 4'b1110);
    chk("arst_led", int'(led_select), 7'b1000000);
    ent = 1'b0;
    cycles(3);
    rst = 1'b0;
    cycles(25);
    chk("arst_no_pulse", int'(state), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/calculator_n.md
CALCULATOR_N -- requirements
Module: calculator_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning operand/result width in bits (1..16).
REQ-002 The block SHALL have parameter NUM_DIGITS, default 4, meaning number of multiplexed 7-seg digits (>= ceil(WIDTH/4)).
REQ-003 The block SHALL have parameter DB_OVERFLOW, default 1000000, meaning consecutive stable cycles required by each debouncer.
REQ-004 The block SHALL have parameter REFRESH_OVERFLOW, default 100000, meaning cycles each digit stays selected.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all logic rising-edge.
REQ-006 The block SHALL have port rst, input, 1 bit, an asynchronous active-high reset.
REQ-007 The block SHALL have port button_ent_undeb, input, 1 bit, a raw enter button.
REQ-008 The block SHALL have port button_clr_undeb, input, 1 bit, a raw clear button.
REQ-009 The block SHALL have port slider_undeb, input, WIDTH bits, raw operand sliders, bit i = weight 2^i.
REQ-010 The block SHALL have port op_select_undeb, input, 2 bits, raw operation select: 00 add, 01 sub, 10 AND, 11 XOR.
REQ-011 The block SHALL have port digit_select, output, NUM_DIGITS bits, active-low digit enables.
REQ-012 The block SHALL have port led_select, output, 7 bits, active-low segments {g,f,e,d,c,b,a}.
REQ-013 The block SHALL have port ovf, output, 1 bit, the carry/borrow flag of the last result.
REQ-014 The block SHALL have port state, output, 2 bits, the FSM state: 00 ENTER_A, 01 ENTER_B, 10 RESULT.

Function
REQ-015 Every raw input bit SHALL pass a 2-FF synchroniser followed by a debouncer; the debounced value updates only after the synchronised value differs from it for DB_OVERFLOW consecutive cycles; any bounce restarts the count.
REQ-016 Enter and clear SHALL each generate a one-cycle pulse on the rising edge of the debounced value; release generates nothing.
REQ-017 In ENTER_A, an ent pulse SHALL load A <= debounced sliders and go to ENTER_B.
REQ-018 In ENTER_B, an ent pulse SHALL load B <= sliders, sample op_select, compute the result, and go to RESULT on the next edge, so the result and ovf are valid one cycle after the pulse.
REQ-019 In RESULT, an ent pulse SHALL load A <= result and go to ENTER_B (chaining); ovf holds until the next compute.
REQ-020 Add SHALL give result = (A+B) mod 2^WIDTH with ovf = carry out.
REQ-021 Sub SHALL give result = (A-B) mod 2^WIDTH with ovf = 1 iff A < B (unsigned).
REQ-022 AND and XOR SHALL be bitwise with ovf = 0.
REQ-023 A clr pulse in any state SHALL clear A, B, result and ovf and go to ENTER_A; when clr and ent pulse in the same cycle, clr wins.
REQ-024 The displayed value SHALL be the live debounced sliders in ENTER_A/ENTER_B and the result in RESULT, zero-extended to 4*NUM_DIGITS bits; digit k shows hex nibble k.
REQ-025 The segment encoding SHALL be standard hex 0-F active-low, e.g. 0=1000000, 1=1111001, 8=0000000, E=0000110, F=0001110.
REQ-026 The refresh counter SHALL advance the digit index every REFRESH_OVERFLOW cycles, wrapping from NUM_DIGITS-1 to 0.
REQ-027 Exactly one digit_select bit SHALL be low at any time, namely bit index; led_select SHALL change in the same cycle as digit_select.

Reset
REQ-028 While rst = 1, all registers SHALL clear asynchronously: debouncers, synchronisers and edge detectors to 0; A = B = result = 0; ovf = 0; state = ENTER_A; digit index 0.
REQ-029 During and after reset, digit_select SHALL be all ones except bit 0 low, and led_select SHALL be 1000000.
REQ-030 Reset asserted mid-operation SHALL abandon any debounce count and any pending computation, with no pulse generated on release of rst.

Verification (WIDTH=4, NUM_DIGITS=4, DB_OVERFLOW=8, REFRESH_OVERFLOW=2)
REQ-031 The bench SHALL cover reset: rst pulse -> state=00, ovf=0, digit_select=1110, led_select=1000000, and digit_select rotating 1101, 1011, 0111, 1110 every 2 cycles.
REQ-032 The bench SHALL cover add with overflow: A=9, ent, B=8, op=00, ent -> state=10, result 1, ovf=1, digit 0 shows 1111001 and digits 1-3 show 1000000.
REQ-033 The bench SHALL cover subtract with borrow: A=3, B=5, op=01 -> result 0xE, ovf=1, digit 0 shows 0000110; then ent -> state=01 with A=0xE (chaining).
REQ-034 The bench SHALL cover bounce rejection: ent toggled high for 5 cycles, then low -> no state change; held for at least 8 cycles plus sync latency -> exactly one transition.
REQ-035 The bench SHALL cover clear priority: in ENTER_B, clr and ent rising in the same cycle -> state=00, ovf=0, A=B=0.
REQ-036 The bench SHALL cover async reset mid-debounce: rst asserted between clock edges -> outputs reach reset values before the next clk edge.
